sipo_word_rx: RTL and testbench
===============================

Name: sipo_word_rx

Overview:
Parametrised serial-in/parallel-out receiver, the successor to the fixed 4-bit SIPO register. It adds:
- configurable word width and bit order
- a shift enable
- a bit counter for word framing
- a captured output word with valid/ack handshake and overrun detection
- a framing re-align input

It sits between a 1-bit serial source and a parallel word consumer.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
LSB_FIRST, 1, 1: first received bit lands in word[0], shifting right with new bit into MSB; 0: first received bit lands in word[WIDTH-1], shifting left with new bit into LSB.

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous active-high reset
en  input  1  sample data this cycle
data  input  1  serial input bit
align  input  1  restart word framing; partial word discarded
word_ack  input  1  consumer accepts word; clears word_valid
q  output  WIDTH  live shift register contents
bit_cnt  output  $clog2(WIDTH)  bits received in current word, 0..WIDTH-1
word  output  WIDTH  last completed word, held until next completion
word_valid  output  1  completed word pending
overrun  output  1  sticky: a word was overwritten before ack

Behaviour:
- One clock (clk). Reset is synchronous and active-high (clear). All state updates on posedge clk.
- clear=1 has priority over all inputs. Next cycle: q=0, bit_cnt=0, word=0, word_valid=0, overrun=0. Applies mid-word too: the partial word is lost.
- en=0, align=0: q and bit_cnt hold. word_valid only changes via word_ack.
- Shift when en=1:
  - LSB_FIRST=1: q <= {data, q[WIDTH-1:1]}
  - LSB_FIRST=0: q <= {q[WIDTH-2:0], data}
- Counting when en=1: bit_cnt <= bit_cnt+1.
- Word completion when en=1 and bit_cnt==WIDTH-1:
  - bit_cnt <= 0.
  - word <= the new shifted q value, including the current bit.
  - word_valid <= 1.
  - Latency: word and word_valid are visible the cycle after the WIDTH-th enabled bit is sampled.
- align=1 (clear=0):
  - With en=0: bit_cnt <= 0.
  - With en=1: the current bit is the first bit of a new word, so bit_cnt <= 1 and q shifts normally.
  - If WIDTH bits would complete in the same cycle as align, align wins and no completion occurs.
  - align never affects word, word_valid or overrun.
- Handshake:
  - word_valid is a level, held until word_ack=1 is sampled while word_valid=1. word_valid then clears next cycle.
  - word_ack while word_valid=0 is ignored.
- Simultaneous completion and word_ack: word updates, word_valid stays 1, overrun unchanged. The old word is consumed.
- Completion while word_valid=1 and word_ack=0: word is overwritten, word_valid stays 1, overrun <= 1.
- overrun is sticky; only clear resets it.
- Cleared state (reset value) is valid for any WIDTH.
- No combinational paths from inputs to outputs. All outputs are registered.

Test Plan:
- WIDTH=8, LSB_FIRST=1, en=1 continuous. Send bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) -> one cycle after the 8th bit: word=0xA5, word_valid=1, bit_cnt=0, q=0xA5. word_ack one cycle later -> word_valid=0.
- WIDTH=4, LSB_FIRST=0. Send 1,0,1,1 with en low for 2 cycles between bits 2 and 3 -> q and bit_cnt hold during gaps (bit_cnt=2 held). word=0xB, word_valid=1 after the 4th enabled bit.
- WIDTH=8, no ack. Send 0x3C then 0xC3 back-to-back -> word=0xC3, word_valid=1, overrun=1. word_ack -> word_valid=0, overrun stays 1 until clear.
- WIDTH=8. Assert word_ack in the same cycle the 8th bit of the second word (0x81) is sampled -> word=0x81, word_valid=1, overrun=0.
- WIDTH=8. After 5 bits, pulse clear -> all outputs 0 next cycle. A following full word 0x5A is received correctly with no residue.
- WIDTH=8. After 3 bits, pulse align with en=1 and data=1 -> bit_cnt=1. 7 more bits then complete a word, whose LSB is the bit sampled with align.

Source files
------------

// File: rtl/sipo_word_rx.sv
// ---------------------------------------------------------------------------
// sipo_word_rx
//
// Serial-in / parallel-out word receiver. A 1-bit serial stream is shifted
// into a WIDTH-bit register while en is high. A bit counter frames the stream
// into WIDTH-bit words. Each completed word is captured into a holding
// register and flagged with word_valid until the consumer acknowledges it.
// Completing a new word while the previous one is still unacknowledged sets
// the sticky overrun flag. align restarts word framing without touching the
// captured word or the handshake state.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   LSB_FIRST  1: first received bit ends up in word[0] (shift right, new bit
//                 enters at the MSB)
//              0: first received bit ends up in word[WIDTH-1] (shift left,
//                 new bit enters at the LSB)
//
// Ports
//   clk         rising-edge clock
//   clear       synchronous active-high reset; overrides all other inputs
//   en          sample data this cycle
//   data        serial input bit
//   align       restart word framing; the partial word is discarded
//   word_ack    consumer accepts the pending word
//   q           live shift register contents
//   bit_cnt     bits received in the current word, 0..WIDTH-1
//   word        last completed word, held until the next completion
//   word_valid  a completed word is pending
//   overrun     sticky: a pending word was overwritten before it was acked
//
// Every output is driven straight from a register; there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module sipo_word_rx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     data,
  input  logic                     align,
  input  logic                     word_ack,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]         word,
  output logic                     word_valid,
  output logic                     overrun
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Registered state
  logic [WIDTH-1:0] shreg_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] word_p0;
  logic             vld_p0;
  logic             ovr_p0;

  // Next-state values
  logic [WIDTH-1:0] shreg_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [WIDTH-1:0] word_nx;
  logic             vld_nx;
  logic             ovr_nx;

  logic [WIDTH-1:0] shifted;
  logic             complete;

  // Insert one serial bit according to the configured bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b);
    if (LSB_FIRST) begin
      return {b, cur[WIDTH-1:1]};
    end else begin
      return {cur[WIDTH-2:0], b};
    end
  endfunction

  // True when the bit being sampled now is the last bit of a word.
  function automatic logic is_last_bit(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_LAST);
  endfunction

  always_comb begin
    shreg_nx = shreg_p0;
    cnt_nx   = cnt_p0;
    word_nx  = word_p0;
    vld_nx   = vld_p0;
    ovr_nx   = ovr_p0;
    complete = 1'b0;

    // The captured word must include the bit sampled in the completing
    // cycle, so it is taken from the shifted value, not from shreg_p0.
    shifted = shift_in(shreg_p0, data);

    if (en) begin
      shreg_nx = shifted;
    end

    // align takes precedence over completion: a bit sampled together with
    // align is the first bit of a fresh word, never the last of an old one.
    if (align) begin
      cnt_nx = en ? CNT_ONE : '0;
    end else if (en) begin
      if (is_last_bit(cnt_p0)) begin
        cnt_nx   = '0;
        complete = 1'b1;
      end else begin
        cnt_nx = cnt_p0 + CNT_ONE;
      end
    end

    // A completion coinciding with word_ack consumes the old word and keeps
    // word_valid high for the new one. Without the ack, the old word is lost.
    if (complete) begin
      word_nx = shifted;
      vld_nx  = 1'b1;
      if (vld_p0 && !word_ack) begin
        ovr_nx = 1'b1;
      end
    end else if (word_ack) begin
      // An ack with nothing pending leaves vld_p0 at zero anyway.
      vld_nx = 1'b0;
    end
  end

  // ---- register stage p0 ----
  always_ff @(posedge clk) begin
    if (clear) begin
      shreg_p0 <= '0;
      cnt_p0   <= '0;
      word_p0  <= '0;
      vld_p0   <= 1'b0;
      ovr_p0   <= 1'b0;
    end else begin
      shreg_p0 <= shreg_nx;
      cnt_p0   <= cnt_nx;
      word_p0  <= word_nx;
      vld_p0   <= vld_nx;
      ovr_p0   <= ovr_nx;
    end
  end

  assign q          = shreg_p0;
  assign bit_cnt    = cnt_p0;
  assign word       = word_p0;
  assign word_valid = vld_p0;
  assign overrun    = ovr_p0;

endmodule

// File: tb/tb_sipo_word_rx.sv
module tb_sipo_word_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: WIDTH=8, LSB first
  logic       clear8, en8, data8, align8, ack8;
  logic [7:0] q8, word8;
  logic [2:0] cnt8;
  logic       wv8, ov8;

  // DUT 1: WIDTH=4, MSB first
  logic       clear4, en4, data4, align4, ack4;
  logic [3:0] q4, word4;
  logic [1:0] cnt4;
  logic       wv4, ov4;

  int checks   = 0;
  int failures = 0;

  sipo_word_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .clk(clk), .clear(clear8), .en(en8), .data(data8), .align(align8),
    .word_ack(ack8), .q(q8), .bit_cnt(cnt8), .word(word8),
    .word_valid(wv8), .overrun(ov8)
  );

  sipo_word_rx #(.WIDTH(4), .LSB_FIRST(1'b0)) dut4 (
    .clk(clk), .clear(clear4), .en(en4), .data(data4), .align(align4),
    .word_ack(ack4), .q(q4), .bit_cnt(cnt4), .word(word4),
    .word_valid(wv4), .overrun(ov4)
  );

  // Reference model: bits since clear, bits of the current word, handshake.
  bit          hist    [2][$];
  bit          cur     [2][$];
  logic [31:0] m_word  [2];
  bit          m_valid [2];
  bit          m_ovr   [2];

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic bit lsb(input int i);
    return (i == 0);
  endfunction

  // The j-th received bit of a word lands at j (LSB first) or WIDTH-1-j.
  function automatic logic [31:0] pack_cur(input int i);
    logic [31:0] v = '0;
    for (int j = 0; j < cur[i].size(); j++)
      if (cur[i][j]) v[lsb(i) ? j : wid(i) - 1 - j] = 1'b1;
    return v;
  endfunction

  // q holds the most recent WIDTH bits; newest at MSB (LSB first) or bit 0.
  function automatic logic [31:0] exp_q(input int i);
    logic [31:0] v = '0;
    int n = hist[i].size();
    for (int k = 0; k < n; k++)
      if (hist[i][n - 1 - k]) v[lsb(i) ? wid(i) - 1 - k : k] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] exp_cnt(input int i);
    return 32'(cur[i].size());
  endfunction

  task automatic model_step(input int i, input bit c, input bit e, input bit d,
                            input bit a, input bit k);
    bit done;
    if (c) begin
      hist[i].delete(); cur[i].delete();
      m_word[i] = '0; m_valid[i] = 0; m_ovr[i] = 0;
      return;
    end
    done = e && !a && (cur[i].size() == wid(i) - 1);
    if (e) begin
      hist[i].push_back(d);
      if (hist[i].size() > wid(i)) void'(hist[i].pop_front());
    end
    if (a) begin
      cur[i].delete();
      if (e) cur[i].push_back(d);
    end else if (e) begin
      cur[i].push_back(d);
    end
    if (done) begin
      m_word[i] = pack_cur(i);
      cur[i].delete();
      if (m_valid[i] && !k) m_ovr[i] = 1;
      m_valid[i] = 1;
    end else if (k && m_valid[i]) begin
      m_valid[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, clear8, en8, data8, align8, ack8);
    model_step(1, clear4, en4, data4, align4, ack4);
    #1;
  endtask

  task automatic drive(input int i, input bit c, input bit e, input bit d,
                       input bit a, input bit k);
    if (i == 0) begin
      clear8 = c; en8 = e; data8 = d; align8 = a; ack8 = k;
    end else begin
      clear4 = c; en4 = e; data4 = d; align4 = a; ack4 = k;
    end
  endtask

  // Send n bits of v in the DUT's bit order; ack only with the last bit.
  task automatic send(input int i, input logic [31:0] v, input int n,
                      input bit ack_last);
    for (int b = 0; b < n; b++) begin
      drive(i, 0, 1, lsb(i) ? v[b] : v[n - 1 - b], 0, ack_last && (b == n - 1));
      tick();
    end
    drive(i, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_clear(input int i);
    drive(i, 1, 0, 0, 0, 0);
    tick();
    drive(i, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 1, 1, 1);
    drive(1, 1, 1, 1, 1, 1);
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if ({q8, cnt8, word8, wv8, ov8} !== 21'b0) begin
      failures++;
      $display("FAIL reset8 got q=%h cnt=%0d word=%h v=%b o=%b want all 0",
               q8, cnt8, word8, wv8, ov8);
    end
    checks++;
    if ({q4, cnt4, word4, wv4, ov4} !== 12'b0) begin
      failures++;
      $display("FAIL reset4 got q=%h cnt=%0d word=%h v=%b o=%b want all 0",
               q4, cnt4, word4, wv4, ov4);
    end
  endtask

  task automatic test_lsb_first();
    pulse_clear(0);
    send(0, 32'hA5, 8, 0);
    checks++;
    if ({word8, wv8, cnt8, q8} !== {8'hA5, 1'b1, 3'd0, 8'hA5}) begin
      failures++;
      $display("FAIL lsb_word got word=%h v=%b cnt=%0d q=%h want A5 1 0 A5",
               word8, wv8, cnt8, q8);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if ({wv8, word8} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL lsb_ack got v=%b word=%h want 0 A5", wv8, word8);
    end
  endtask

  task automatic test_msb_first_gaps();
    pulse_clear(1);
    send(1, 32'h2, 2, 0);              // bits 1,0
    for (int g = 0; g < 2; g++) begin
      drive(1, 0, 0, $urandom_range(0, 1), 0, 0);
      tick();
      checks++;
      if ({q4, cnt4} !== {4'h2, 2'd2}) begin
        failures++;
        $display("FAIL gap_hold%0d got q=%h cnt=%0d want 2 2", g, q4, cnt4);
      end
    end
    send(1, 32'h3, 2, 0);              // bits 1,1
    checks++;
    if ({word4, wv4, q4, cnt4} !== {4'hB, 1'b1, 4'hB, 2'd0}) begin
      failures++;
      $display("FAIL msb_word got word=%h v=%b q=%h cnt=%0d want B 1 B 0",
               word4, wv4, q4, cnt4);
    end
  endtask

  task automatic test_overrun();
    pulse_clear(0);
    send(0, 32'h3C, 8, 0);
    send(0, 32'hC3, 8, 0);
    checks++;
    if ({word8, wv8, ov8} !== {8'hC3, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL overrun got word=%h v=%b o=%b want C3 1 1", word8, wv8, ov8);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    checks++;
    if ({wv8, ov8} !== 2'b01) begin
      failures++;
      $display("FAIL overrun_sticky got v=%b o=%b want 0 1", wv8, ov8);
    end
    pulse_clear(0);
    checks++;
    if (ov8 !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got o=%b want 0", ov8);
    end
  endtask

  task automatic test_ack_same_cycle();
    pulse_clear(0);
    send(0, 32'h3C, 8, 0);
    send(0, 32'h81, 8, 1);
    checks++;
    if ({word8, wv8, ov8} !== {8'h81, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ack_same got word=%h v=%b o=%b want 81 1 0", word8, wv8, ov8);
    end
  endtask

  task automatic test_clear_mid_word();
    pulse_clear(0);
    send(0, $urandom, 5, 0);
    drive(0, 1, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if ({q8, cnt8, word8, wv8, ov8} !== 21'b0) begin
      failures++;
      $display("FAIL clear_mid got q=%h cnt=%0d word=%h v=%b o=%b want all 0",
               q8, cnt8, word8, wv8, ov8);
    end
    send(0, 32'h5A, 8, 0);
    checks++;
    if ({word8, q8, wv8, cnt8} !== {8'h5A, 8'h5A, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL clear_then_word got word=%h q=%h v=%b cnt=%0d want 5A 5A 1 0",
               word8, q8, wv8, cnt8);
    end
  endtask

  task automatic test_align();
    logic [7:0] r = 8'($urandom);
    pulse_clear(0);
    send(0, $urandom, 3, 0);
    drive(0, 0, 1, 1, 1, 0);
    tick();
    checks++;
    if ({cnt8, wv8} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL align_cnt got cnt=%0d v=%b want 1 0", cnt8, wv8);
    end
    send(0, 32'(r >> 1), 7, 0);
    checks++;
    if ({word8, wv8, cnt8} !== {r[7:1], 1'b1, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL align_word got word=%h v=%b cnt=%0d want %h 1 0",
               word8, wv8, cnt8, {r[7:1], 1'b1});
    end
    // align with en=0 zeroes the count without shifting
    drive(0, 0, 0, 0, 0, 1);
    tick();
    send(0, $urandom, 4, 0);
    drive(0, 0, 0, 1, 1, 0);
    tick();
    checks++;
    if ({cnt8, q8} !== {3'd0, 8'(exp_q(0))}) begin
      failures++;
      $display("FAIL align_noen got cnt=%0d q=%h want 0 %h", cnt8, q8, exp_q(0));
    end
    // align on what would be the completing bit: no completion
    send(0, $urandom, 7, 0);
    drive(0, 0, 1, $urandom_range(0, 1), 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if ({cnt8, wv8, word8} !== {3'd1, 1'b0, r[7:1], 1'b1}) begin
      failures++;
      $display("FAIL align_wins got cnt=%0d v=%b word=%h want 1 0 %h",
               cnt8, wv8, word8, {r[7:1], 1'b1});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      drive(0, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
            $urandom_range(0, 1), $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 20);
      drive(1, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
            $urandom_range(0, 1), $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 20);
      tick();
      checks++;
      if ({32'(q8), 32'(cnt8), 32'(word8), wv8, ov8} !==
          {exp_q(0), exp_cnt(0), m_word[0], m_valid[0], m_ovr[0]}) begin
        failures++;
        $display("FAIL rand8 cyc=%0d got q=%h cnt=%0d w=%h v=%b o=%b want q=%h cnt=%0d w=%h v=%b o=%b",
                 n, q8, cnt8, word8, wv8, ov8, exp_q(0), exp_cnt(0),
                 m_word[0], m_valid[0], m_ovr[0]);
      end
      checks++;
      if ({32'(q4), 32'(cnt4), 32'(word4), wv4, ov4} !==
          {exp_q(1), exp_cnt(1), m_word[1], m_valid[1], m_ovr[1]}) begin
        failures++;
        $display("FAIL rand4 cyc=%0d got q=%h cnt=%0d w=%h v=%b o=%b want q=%h cnt=%0d w=%h v=%b o=%b",
                 n, q4, cnt4, word4, wv4, ov4, exp_q(1), exp_cnt(1),
                 m_word[1], m_valid[1], m_ovr[1]);
      end
    end
  endtask

  initial begin
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    test_reset();
    test_lsb_first();
    test_msb_first_gaps();
    test_overrun();
    test_ack_same_cycle();
    test_clear_mid_word();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
